// File: rtl/cnn_pkg.sv
// Shared definitions for the convolution engine: sequencer state encoding and
// default geometry constants used by the window buffer and multiply-adder trees.
package cnn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT_UP,
        ST_SCAN,
        ST_DRAIN
    } state_t;

    localparam int DEF_IMG_W      = 320;
    localparam int DEF_IMG_H      = 240;
    localparam int DEF_K          = 8;
    localparam int DEF_MA_LATENCY = 6;

endpackage

// File: rtl/valid_delay.sv
// Fixed-length valid shift register with asynchronous clear; aligns the window
// strobe with the rectified result leaving the multiply-adder pipeline.
module valid_delay #(
    parameter int STAGES = 6
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] vld_p;

    generate
        if (STAGES == 1) begin : g_single
            always_ff @(posedge clock or posedge reset) begin
                if (reset) vld_p <= '0;
                else       vld_p <= din;
            end
        end else begin : g_chain
            always_ff @(posedge clock or posedge reset) begin
                if (reset) vld_p <= '0;
                else       vld_p <= {vld_p[STAGES-2:0], din};
            end
        end
    endgenerate

    assign dout = vld_p[STAGES-1];

endmodule

// File: rtl/window_scan_ctrl.sv
// Shifting-window sequencer: loads raster rows into the window buffer, scans one
// window per cycle once K rows are present, and generates feature-map write-back.
module window_scan_ctrl
    import cnn_pkg::*;
#(
    parameter int IMG_W      = DEF_IMG_W,
    parameter int IMG_H      = DEF_IMG_H,
    parameter int K          = DEF_K,
    parameter int MA_LATENCY = DEF_MA_LATENCY,
    localparam int XW = $clog2(IMG_W),
    localparam int YW = $clog2(K),
    localparam int AW = $clog2((IMG_W - K + 1) * (IMG_H - K + 1))
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          frame_start,
    input  logic          pixel_valid,
    output logic          pixel_ready,
    output logic          shift_left,
    output logic          shift_up,
    output logic [XW-1:0] kernel_x,
    output logic [YW-1:0] kernel_y,
    output logic          window_valid,
    output logic          fm_wr_en,
    output logic [AW-1:0] fm_wr_addr,
    output logic          busy,
    output logic          frame_done
);

    localparam int RW = $clog2(IMG_H + 1);
    localparam int DW = (MA_LATENCY > 1) ? $clog2(MA_LATENCY) : 1;

    localparam logic [XW-1:0] COL_LAST   = XW'(IMG_W - 1);
    localparam logic [XW-1:0] KX_FIRST   = XW'(K - 1);
    localparam logic [RW-1:0] ROW_K      = RW'(K);
    localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_H);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(MA_LATENCY - 1);

    state_t        state;
    logic [XW-1:0] col;
    logic [RW-1:0] row;
    logic [RW-1:0] row_next;
    logic [DW-1:0] drain_cnt;
    logic          accept;
    logic          start_ok;

    assign accept     = pixel_valid & pixel_ready;
    assign shift_left = accept;
    assign kernel_y   = YW'(K - 1);
    assign row_next   = row + 1'b1;
    assign start_ok   = (state == ST_IDLE) & frame_start;

    // Outputs are registered, so each transition sets the values for the state being entered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            col          <= '0;
            row          <= '0;
            drain_cnt    <= '0;
            pixel_ready  <= 1'b0;
            shift_up     <= 1'b0;
            window_valid <= 1'b0;
            kernel_x     <= '0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            shift_up   <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (frame_start) begin
                        col         <= '0;
                        row         <= '0;
                        state       <= ST_LOAD;
                        pixel_ready <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        col <= col + 1'b1;
                        if (col == COL_LAST) begin
                            state       <= ST_SHIFT_UP;
                            pixel_ready <= 1'b0;
                            shift_up    <= 1'b1;
                        end
                    end
                end
                ST_SHIFT_UP: begin
                    col <= '0;
                    row <= row_next;
                    if (row_next >= ROW_K) begin
                        state        <= ST_SCAN;
                        window_valid <= 1'b1;
                        kernel_x     <= KX_FIRST;
                    end else begin
                        state       <= ST_LOAD;
                        pixel_ready <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (kernel_x == COL_LAST) begin
                        window_valid <= 1'b0;
                        if (row == ROW_LAST) begin
                            state     <= ST_DRAIN;
                            drain_cnt <= '0;
                        end else begin
                            state       <= ST_LOAD;
                            pixel_ready <= 1'b1;
                        end
                    end else begin
                        kernel_x <= kernel_x + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state      <= ST_IDLE;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    pixel_ready <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

    valid_delay #(
        .STAGES(MA_LATENCY)
    ) u_valid_delay (
        .clock(clock),
        .reset(reset),
        .din  (window_valid),
        .dout (fm_wr_en)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset)         fm_wr_addr <= '0;
        else if (start_ok) fm_wr_addr <= '0;
        else if (fm_wr_en) fm_wr_addr <= fm_wr_addr + 1'b1;
    end

endmodule

// File: tb/tb_window_scan_ctrl.sv
// Randomized bench for window_scan_ctrl on a 6x5 image with a 3x3 kernel.
module tb_window_scan_ctrl;

    localparam int IMG_W = 6;
    localparam int IMG_H = 5;
    localparam int K     = 3;
    localparam int L     = 4;
    localparam int OUT_W = IMG_W - K + 1;
    localparam int OUT_H = IMG_H - K + 1;
    localparam int NWIN  = OUT_W * OUT_H;

    logic       clock = 1'b0;
    logic       reset;
    logic       frame_start;
    logic       pixel_valid;
    logic       pixel_ready;
    logic       shift_left;
    logic       shift_up;
    logic [2:0] kernel_x;
    logic [1:0] kernel_y;
    logic       window_valid;
    logic       fm_wr_en;
    logic [3:0] fm_wr_addr;
    logic       busy;
    logic       frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    window_scan_ctrl #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .MA_LATENCY(L)
    ) dut (
        .clock(clock), .reset(reset), .frame_start(frame_start),
        .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
        .shift_left(shift_left), .shift_up(shift_up),
        .kernel_x(kernel_x), .kernel_y(kernel_y),
        .window_valid(window_valid), .fm_wr_en(fm_wr_en),
        .fm_wr_addr(fm_wr_addr), .busy(busy), .frame_done(frame_done)
    );

    // Event log: cycle stamps of every observable strobe, sampled mid-cycle.
    int cyc = 0;
    int acc_q[$], su_q[$], win_cyc[$], win_kx[$], wr_cyc[$], wr_addr[$], done_q[$];
    int viol = 0;

    always @(negedge clock) begin
        cyc++;
        if (shift_left)   acc_q.push_back(cyc);
        if (shift_up)     su_q.push_back(cyc);
        if (window_valid) begin
            win_cyc.push_back(cyc);
            win_kx.push_back(int'(kernel_x));
        end
        if (fm_wr_en) begin
            wr_cyc.push_back(cyc);
            wr_addr.push_back(int'(fm_wr_addr));
        end
        if (frame_done) done_q.push_back(cyc);
        if (shift_left && !pixel_ready) viol++;
        if (pixel_ready && (shift_up || window_valid)) viol++;
    end

    task automatic clear_mon();
        acc_q.delete(); su_q.delete(); win_cyc.delete(); win_kx.delete();
        wr_cyc.delete(); wr_addr.delete(); done_q.delete();
        viol = 0;
    endtask

    task automatic run_frame(input int gap_pct, input bit spurious);
        bit done;
        clear_mon();
        @(posedge clock); #1;
        frame_start = 1'b1;
        @(posedge clock); #1;
        frame_start = 1'b0;
        done = 1'b0;
        for (int t = 0; t < 2000 && !done; t++) begin
            pixel_valid = (int'($urandom_range(99)) >= gap_pct);
            frame_start = (spurious && t == 10);
            @(posedge clock); #1;
            if (done_q.size() > 0) done = 1'b1;
        end
        pixel_valid = 1'b0;
        frame_start = 1'b0;
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL frame_timeout: frame_done not seen, got %0d pulses required 1", done_q.size());
        end
    endtask

    task automatic check_frame(input string name, input bit continuous);
        bit sizes_ok;
        n_checks++;
        if (acc_q.size() !== IMG_W * IMG_H) begin
            n_fail++;
            $display("FAIL %s shift_left_count: got %0d required %0d", name, acc_q.size(), IMG_W * IMG_H);
        end
        n_checks++;
        if (su_q.size() !== IMG_H) begin
            n_fail++;
            $display("FAIL %s shift_up_count: got %0d required %0d", name, su_q.size(), IMG_H);
        end
        n_checks++;
        if (win_cyc.size() !== NWIN) begin
            n_fail++;
            $display("FAIL %s window_count: got %0d required %0d", name, win_cyc.size(), NWIN);
        end
        n_checks++;
        if (wr_cyc.size() !== NWIN) begin
            n_fail++;
            $display("FAIL %s write_count: got %0d required %0d", name, wr_cyc.size(), NWIN);
        end
        n_checks++;
        if (done_q.size() !== 1) begin
            n_fail++;
            $display("FAIL %s done_count: got %0d required 1", name, done_q.size());
        end
        n_checks++;
        if (viol !== 0) begin
            n_fail++;
            $display("FAIL %s handshake_violations: got %0d required 0", name, viol);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy_after_frame: got %0b required 0", name, busy);
        end
        sizes_ok = (acc_q.size() == IMG_W * IMG_H) && (su_q.size() == IMG_H) &&
                   (win_cyc.size() == NWIN) && (wr_cyc.size() == NWIN) && (done_q.size() == 1);
        if (sizes_ok) begin
            for (int i = 0; i < NWIN; i++) begin
                n_checks++;
                if (win_kx[i] !== K - 1 + i % OUT_W) begin
                    n_fail++;
                    $display("FAIL %s kernel_x[%0d]: got %0d required %0d", name, i, win_kx[i], K - 1 + i % OUT_W);
                end
                n_checks++;
                if (wr_addr[i] !== i) begin
                    n_fail++;
                    $display("FAIL %s wr_addr[%0d]: got %0d required %0d", name, i, wr_addr[i], i);
                end
                n_checks++;
                if (wr_cyc[i] !== win_cyc[i] + L) begin
                    n_fail++;
                    $display("FAIL %s wr_latency[%0d]: got %0d required %0d", name, i, wr_cyc[i] - win_cyc[i], L);
                end
            end
            for (int r = 0; r < IMG_H; r++) begin
                n_checks++;
                if (su_q[r] !== acc_q[r * IMG_W + IMG_W - 1] + 1) begin
                    n_fail++;
                    $display("FAIL %s shift_up_timing[%0d]: got cycle %0d required %0d", name, r, su_q[r], acc_q[r * IMG_W + IMG_W - 1] + 1);
                end
            end
            for (int b = 0; b < OUT_H; b++) begin
                n_checks++;
                if (win_cyc[b * OUT_W] !== acc_q[(K - 1 + b) * IMG_W + IMG_W - 1] + 2) begin
                    n_fail++;
                    $display("FAIL %s first_window_timing[%0d]: got cycle %0d required %0d", name, b, win_cyc[b * OUT_W], acc_q[(K - 1 + b) * IMG_W + IMG_W - 1] + 2);
                end
            end
            n_checks++;
            if (done_q[0] !== win_cyc[NWIN - 1] + L + 1) begin
                n_fail++;
                $display("FAIL %s done_timing: got %0d after last window required %0d", name, done_q[0] - win_cyc[NWIN - 1], L + 1);
            end
            if (continuous) begin
                n_checks++;
                if (done_q[0] - acc_q[0] !== IMG_W * IMG_H + IMG_H + NWIN + L) begin
                    n_fail++;
                    $display("FAIL %s frame_time: got %0d required %0d", name, done_q[0] - acc_q[0] + 1, IMG_W * IMG_H + IMG_H + NWIN + L + 1);
                end
            end
        end
    endtask

    task automatic check_outputs_zero(input string name);
        n_checks++;
        if ({pixel_ready, shift_left, shift_up, window_valid, fm_wr_en, busy, frame_done, kernel_x, fm_wr_addr} !== '0) begin
            n_fail++;
            $display("FAIL %s outputs: got rdy=%0b sl=%0b su=%0b wv=%0b we=%0b busy=%0b done=%0b kx=%0d addr=%0d required all 0",
                     name, pixel_ready, shift_left, shift_up, window_valid, fm_wr_en, busy, frame_done, kernel_x, fm_wr_addr);
        end
        n_checks++;
        if (kernel_y !== 2'd2) begin
            n_fail++;
            $display("FAIL %s kernel_y: got %0d required 2", name, kernel_y);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            frame_start = 1'($urandom_range(1));
            pixel_valid = 1'($urandom_range(1));
            @(negedge clock);
            check_outputs_zero("reset_values");
        end
        @(posedge clock); #1;
        frame_start = 1'b0;
        pixel_valid = 1'b0;
        reset       = 1'b0;
    endtask

    task automatic test_full_frame();
        run_frame(0, 1'b0);
        check_frame("full_frame", 1'b1);
    endtask

    task automatic test_gapped();
        run_frame(50, 1'b0);
        check_frame("gapped", 1'b0);
    endtask

    task automatic test_backpressure();
        run_frame(0, 1'b0);
        check_frame("backpressure", 1'b1);
        if (acc_q.size() == IMG_W * IMG_H && su_q.size() == IMG_H && win_cyc.size() == NWIN) begin
            for (int r = 0; r < K - 1; r++) begin
                n_checks++;
                if (acc_q[(r + 1) * IMG_W] !== su_q[r] + 1) begin
                    n_fail++;
                    $display("FAIL backpressure_accept_after_shift_up[%0d]: got cycle %0d required %0d", r, acc_q[(r + 1) * IMG_W], su_q[r] + 1);
                end
            end
            for (int b = 0; b < OUT_H - 1; b++) begin
                n_checks++;
                if (acc_q[(K + b) * IMG_W] !== win_cyc[b * OUT_W + OUT_W - 1] + 1) begin
                    n_fail++;
                    $display("FAIL backpressure_accept_after_scan[%0d]: got cycle %0d required %0d", b, acc_q[(K + b) * IMG_W], win_cyc[b * OUT_W + OUT_W - 1] + 1);
                end
            end
        end
    endtask

    task automatic test_spurious_start();
        run_frame(0, 1'b1);
        check_frame("spurious_start", 1'b1);
    endtask

    task automatic test_reset_mid();
        bit hit;
        clear_mon();
        @(posedge clock); #1;
        frame_start = 1'b1;
        pixel_valid = 1'b1;
        @(posedge clock); #1;
        frame_start = 1'b0;
        hit = 1'b0;
        for (int t = 0; t < 500 && !hit; t++) begin
            @(negedge clock); #1;
            if (win_cyc.size() >= 6) hit = 1'b1;
        end
        n_checks++;
        if (!hit) begin
            n_fail++;
            $display("FAIL reset_mid_reach_scan: got %0d windows required 6", win_cyc.size());
        end
        #1;
        reset = 1'b1;
        #1;
        check_outputs_zero("reset_mid_immediate");
        @(posedge clock); @(posedge clock); #1;
        reset       = 1'b0;
        pixel_valid = 1'b0;
        clear_mon();
        repeat (20) @(posedge clock);
        #1;
        n_checks++;
        if (wr_cyc.size() !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_stale_writes: got %0d writes required 0", wr_cyc.size());
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_busy: got %0b required 0", busy);
        end
        run_frame(30, 1'b0);
        check_frame("after_reset", 1'b0);
    endtask

    initial begin
        reset       = 1'b1;
        frame_start = 1'b0;
        pixel_valid = 1'b0;
        test_reset();
        test_full_frame();
        test_gapped();
        test_backpressure();
        test_spurious_start();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/window_scan_ctrl.md
# window_scan_ctrl

Sequencer for the shifting-window datapath of the convolution engine. Accepts a raster pixel stream under a valid/ready handshake and drives the window buffer's `shift_left`/`shift_up` and kernel-position selects. Issues one window per cycle to the multiply-adder trees. Tracks the multiply-adder plus rectifier pipeline latency so it can generate feature-map buffer write enables and addresses, and signals frame completion.

## Interface
- `IMG_W`, 320: input image width in pixels.
- `IMG_H`, 240: input image height in rows.
- `K`, 8: kernel edge size. Window buffer holds K rows of IMG_W pixels.
- `MA_LATENCY`, 6: cycles from window presented to rectified result valid; must be ≥1.
- Derived: OUT_W = IMG_W−K+1, OUT_H = IMG_H−K+1, XW = clog2(IMG_W), YW = clog2(K), AW = clog2(OUT_W·OUT_H).

Ports:
- `clock`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-high.
- `frame_start`  in  1  single-cycle pulse; starts a frame from IDLE.
- `pixel_valid`  in  1  upstream pixel present.
- `pixel_ready`  out  1  controller accepts a pixel this cycle.
- `shift_left`  out  1  shift the window buffer by one pixel (accept strobe).
- `shift_up`  out  1  shift the window buffer by one row.
- `kernel_x`  out  XW  column of the window's bottom-right corner.
- `kernel_y`  out  YW  row of the window's bottom-right corner; constant K−1.
- `window_valid`  out  1  `kernel_x`/`kernel_y` select a valid window this cycle.
- `fm_wr_en`  out  1  feature-map buffer write strobe.
- `fm_wr_addr`  out  AW  raster address of the output pixel being written.
- `busy`  out  1  high in every state except IDLE.
- `frame_done`  out  1  single-cycle pulse at end of frame.

## Operation
The controller is a state machine with five states: IDLE, LOAD, SHIFT_UP, SCAN and DRAIN. It uses a column counter `col`, a row counter `row` (rows loaded), and a drain counter.

- **IDLE:** `pixel_ready`=0. On `frame_start` it clears `col`, `row` and `fm_wr_addr`, then goes to LOAD.
- **LOAD:** `pixel_ready`=1.
  - An accept is `pixel_valid & pixel_ready`. `shift_left` equals the accept, combinationally.
  - Each accept increments `col`.
  - An accept with `col`==IMG_W−1 goes to SHIFT_UP.
  - Gaps in `pixel_valid` simply hold state.
- **SHIFT_UP:** one cycle, `shift_up`=1, `pixel_ready`=0. Then `col`←0 and `row`←`row`+1.
  - If the new `row` ≥ K, go to SCAN with `kernel_x`←K−1.
  - Otherwise go to LOAD.
- **SCAN:** `pixel_ready`=0, `window_valid`=1. `kernel_x` increments each cycle from K−1 to IMG_W−1, giving exactly OUT_W cycles. At IMG_W−1:
  - If `row`==IMG_H, go to DRAIN.
  - Otherwise go to LOAD.
- **DRAIN:** counts MA_LATENCY cycles, then pulses `frame_done` for one cycle and returns to IDLE.

Write-back path:
- `fm_wr_en` is `window_valid` delayed by exactly MA_LATENCY cycles.
- `fm_wr_addr` increments after each write and is cleared on accepted `frame_start`.
- A frame produces exactly OUT_W·OUT_H writes, at addresses 0 … OUT_W·OUT_H−1.

Boundary conditions:
- `frame_start` outside IDLE is ignored.
- `pixel_valid` while `pixel_ready`=0 produces no `shift_left` and no counter change.
- `kernel_x` holds its last value outside SCAN. Downstream qualifies it with `window_valid`.
- Reset at any time returns to IDLE immediately and flushes the latency pipe, so no stale `fm_wr_en` appears after reset.

## Timing
- All outputs reset to 0, except `kernel_y`, which is tied to K−1.
- `pixel_ready`, `shift_up`, `window_valid`, `kernel_x`, `busy` and `frame_done` are registered. `shift_left` is combinational from `pixel_valid`.
- Row load to first window:
  - last pixel of the row accepted at cycle t;
  - `shift_up` at t+1;
  - first `window_valid` at t+2.
- End of frame: last `window_valid` at cycle s, last `fm_wr_en` at s+MA_LATENCY, `frame_done` at s+MA_LATENCY+1.
- Minimum frame time with continuous valid is IMG_W·IMG_H + IMG_H + OUT_H·OUT_W + MA_LATENCY + 1 cycles.

## Structure
- Shared package `cnn_pkg` holds:
  - the state enum (`ST_IDLE`, `ST_LOAD`, `ST_SHIFT_UP`, `ST_SCAN`, `ST_DRAIN`);
  - default K, IMG_W, IMG_H and MA_LATENCY constants, shared with `window_wrapper` and the multiply-adder trees.
- One sub-module, `valid_delay`: a parameterised MA_LATENCY-stage shift register with asynchronous clear, used for `window_valid` → `fm_wr_en`.

## Test plan
All scenarios use IMG_W=6, IMG_H=5, K=3, MA_LATENCY=4, giving OUT_W=4 and OUT_H=3.

- **Reset values:** assert `reset` with random inputs → every output is 0, `kernel_y`=2, `busy`=0.
- **Full frame, continuous valid:** `frame_start`, then `pixel_valid` held high →
  - 30 `shift_left` pulses and 5 `shift_up` pulses;
  - 3 SCAN bursts, each with `kernel_x`=2,3,4,5;
  - 12 `fm_wr_en` at addresses 0…11, each exactly 4 cycles after its window;
  - `frame_done` 5 cycles after the last window.
- **Gapped stream:** `pixel_valid` with 50% random gaps → same counts, addresses and `kernel_x` sequence as the full-frame case.
- **Backpressure:** `pixel_valid`=1 during SHIFT_UP and SCAN → `pixel_ready`=0 and no `shift_left`; the pixel is accepted on the first LOAD cycle.
- **Spurious start:** `frame_start` pulsed mid-LOAD → ignored; the frame completes with 12 writes.
- **Reset mid-operation:** `reset` asserted mid-SCAN with writes pending → outputs are 0 immediately and no `fm_wr_en` appears afterward. A new `frame_start` then yields a correct 12-write frame starting at address 0.
